blinky_sequencer: RTL and testbench
===================================

# blinky_sequencer

LED pattern engine for the Tang Nano 9k Blinky design. It runs in the PLL output clock domain (27 MHz × 13/7 ≈ 50.143 MHz) and consumes that clock directly. It derives a slow step tick, debounces the user button and drives the six active-low board LEDs with one of three selectable patterns.

## Interface
- `CLK_HZ`, default 50142857: frequency of `clk` in Hz.
- `STEP_HZ`, default 4: pattern step rate. Divider `DIV = CLK_HZ / STEP_HZ` (integer division); elaboration error if `DIV < 2`.
- `DEBOUNCE_CYCLES`, default 501428: consecutive stable cycles required to accept a button level (≈10 ms). Must be ≥ 1.
- `clk`  in  1  PLL clkout; the only clock.
- `reset`  in  1  asynchronous, active-high reset.
- `btn_n`  in  1  raw user button, active-low, asynchronous to `clk`.
- `led_n`  out  6  LED drive, active-low; bit 0 = LED0.
- `mode`  out  2  current pattern: 0 = BINARY, 1 = CHASE, 2 = BLINK.

## Operation
- **Reset state:**
  - `led_n` = 6'b111111; `mode` = 0.
  - Sync flops = 1; debounced level = 1; debounce count = 0.
  - Prescaler = 0; count = 0; pos = 0; dir = up; phase = 0.
- **Button path:**
  - 2-FF synchronizer on `btn_n`.
  - Debounce counter increments while the synced level ≠ stable level, and clears when they are equal.
  - When the counter reaches `DEBOUNCE_CYCLES`, the stable level takes the synced value and the counter clears.
  - `press` is a 1-cycle pulse on a stable 1→0 transition. Releases generate nothing.
- **Prescaler:**
  - Counts 0..DIV-1; `tick` is high while count = DIV-1, then the count wraps to 0.
- **Mode FSM (BINARY → CHASE → BLINK → BINARY):** advances on `press`. Encoding 3 is unreachable; if reached, it recovers to BINARY on the next edge.
- **On `press`:**
  - Pattern state resets (count = 0, pos = 0, dir = up, phase = 0) and the prescaler clears to 0.
  - If `press` and `tick` occur in the same cycle, `press` wins and the tick is discarded.
- **Patterns, advanced on `tick`:**
  - BINARY: 6-bit count increments, wrapping 63→0; `led_n = ~count`.
  - CHASE: pos bounces 0,1,2,3,4,5,4,3,2,1,0,1…
    - At pos 5 going up, dir flips to down and pos becomes 4.
    - At pos 0 going down, dir flips to up and pos becomes 1.
    - `led_n = ~(1 << pos)`.
  - BLINK: phase toggles; `led_n` = 6'b000000 when phase = 1 (all on), else 6'b111111.
- Only the active mode's state advances; inactive pattern state holds.
- **Reset mid-operation:** all state returns to the reset values immediately (asynchronous). Any debounce in progress is lost.

## Timing
- Step tick latency: `tick` high in cycle N → pattern state updates at the edge ending N → `led_n` updates at the next edge, i.e. it is registered and visible in cycle N+2.
- Step period is exactly DIV cycles. The first tick after reset or `press` occurs in the DIV-th cycle of counting.
- Button latency: 2 sync cycles + `DEBOUNCE_CYCLES` → `press` pulse → `mode` and cleared state visible the next cycle → `led_n` one cycle later.
- Glitches shorter than `DEBOUNCE_CYCLES` produce no `press`.
- `mode` is registered and changes only on `press` or `reset`.

## Structure
- **Package `blinky_pkg`:**
  - mode enum (`MODE_BINARY = 2'd0`, `MODE_CHASE = 2'd1`, `MODE_BLINK = 2'd2`)
  - `LED_COUNT = 6`
  - board default `CLK_HZ` constant
- **Sub-module `btn_debounce`:** synchronizer, debounce counter and press-pulse generator, parameterized by `DEBOUNCE_CYCLES`. Counter width = `$clog2(DEBOUNCE_CYCLES+1)`.
- **Top level:** prescaler (width `$clog2(DIV)`), mode FSM, pattern registers and the registered LED decode.

## Test plan
All scenarios use `CLK_HZ=100`, `STEP_HZ=10` (DIV = 10) and `DEBOUNCE_CYCLES=4`.
- **Reset, idle:** `btn_n` = 1 for 700 cycles. `led_n` steps ~0, ~1, ~2… every 10 cycles and wraps from ~63 to ~0 after 64 ticks; `mode` = 0 throughout.
- **Debounce:**
  - `btn_n` low for 3 cycles then high: no `press`, `mode` stays 0.
  - `btn_n` low for 10 cycles: exactly one `press`, `mode` = 1, then `led_n` = 6'b111110.
- **CHASE bounce:** over 12 ticks, pos follows 0,1,2,3,4,5,4,3,2,1,0,1,2 and `led_n` is the one-cold pattern matching each step.
- **BLINK and wrap:**
  - Second press → `mode` = 2; `led_n` alternates 6'b111111 / 6'b000000 every 10 cycles.
  - Third press → `mode` = 0 and `led_n` = 6'b111111.
- **Simultaneous events:** a `press` aligned with the cycle where the prescaler = 9 gives no pattern advance in that cycle; the next step occurs 10 cycles later.
- **Reset mid-operation:** in CHASE at pos 3, assert `reset` asynchronously between edges. `led_n` = 6'b111111 and `mode` = 0 immediately; after release, BINARY restarts from count 0.

Source files
------------

// File: rtl/blinky_pkg.sv
// Shared definitions for the Tang Nano 9k blinky LED pattern engine.
package blinky_pkg;

    typedef enum logic [1:0] {
        MODE_BINARY = 2'd0,
        MODE_CHASE  = 2'd1,
        MODE_BLINK  = 2'd2
    } mode_e;

    localparam int LED_COUNT    = 6;
    localparam int BOARD_CLK_HZ = 50142857;

    // Pattern order on each button press; the unused encoding falls back to BINARY.
    function automatic logic [1:0] next_mode(input logic [1:0] cur);
        case (cur)
            MODE_BINARY: return MODE_CHASE;
            MODE_CHASE:  return MODE_BLINK;
            default:     return MODE_BINARY;
        endcase
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Button synchronizer and debouncer; emits a one-cycle pulse on each accepted press.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 501428
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_n,
    output logic press
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
        $error("btn_debounce: DEBOUNCE_CYCLES must be at least 1");
    end

    logic             sync1_q;
    logic             sync2_q;
    logic             stable_q;
    logic [CNT_W-1:0] cnt_q;

    // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q  <= 1'b1;
            sync2_q  <= 1'b1;
            stable_q <= 1'b1;
            cnt_q    <= '0;
            press    <= 1'b0;
        end else begin
            sync1_q <= btn_n;
            sync2_q <= sync1_q;
            press   <= 1'b0;
            if (sync2_q == stable_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CNT_LAST) begin
                // Level has differed long enough: accept it; only a falling edge is a press.
                stable_q <= sync2_q;
                cnt_q    <= '0;
                press    <= ~sync2_q;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/blinky_sequencer.sv
// LED pattern engine: step prescaler, mode selection on button press and registered LED drive.
module blinky_sequencer
    import blinky_pkg::*;
#(
    parameter int CLK_HZ          = BOARD_CLK_HZ,
    parameter int STEP_HZ         = 4,
    parameter int DEBOUNCE_CYCLES = 501428
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 btn_n,
    output logic [LED_COUNT-1:0] led_n,
    output logic [1:0]           mode
);

    localparam int DIV   = CLK_HZ / STEP_HZ;
    localparam int PRE_W = (DIV < 2) ? 1 : $clog2(DIV);
    localparam logic [PRE_W-1:0]     PRE_LAST = PRE_W'(DIV - 1);
    localparam logic [LED_COUNT-1:0] LED_ONE  = 1;

    if (DIV < 2) begin : g_bad_div
        $error("blinky_sequencer: CLK_HZ / STEP_HZ must be at least 2");
    end

    logic                 press;
    logic                 tick;
    logic [PRE_W-1:0]     pre_q;
    logic [LED_COUNT-1:0] count_q;
    logic [2:0]           pos_q;
    logic                 dir_down_q;
    logic                 phase_q;

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_btn (
        .clk   (clk),
        .reset (reset),
        .btn_n (btn_n),
        .press (press)
    );

    assign tick = (pre_q == PRE_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pre_q <= '0;
        end else if (press || tick) begin
            pre_q <= '0;
        end else begin
            pre_q <= pre_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mode <= MODE_BINARY;
        end else if (mode == 2'd3) begin
            mode <= MODE_BINARY;
        end else if (press) begin
            mode <= next_mode(mode);
        end
    end

    // A press restarts the pattern and swallows any tick landing in the same cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q    <= '0;
            pos_q      <= '0;
            dir_down_q <= 1'b0;
            phase_q    <= 1'b0;
        end else if (press) begin
            count_q    <= '0;
            pos_q      <= '0;
            dir_down_q <= 1'b0;
            phase_q    <= 1'b0;
        end else if (tick) begin
            case (mode)
                MODE_BINARY: count_q <= count_q + 1'b1;
                MODE_CHASE: begin
                    if (!dir_down_q && pos_q == 3'd5) begin
                        dir_down_q <= 1'b1;
                        pos_q      <= 3'd4;
                    end else if (dir_down_q && pos_q == 3'd0) begin
                        dir_down_q <= 1'b0;
                        pos_q      <= 3'd1;
                    end else if (dir_down_q) begin
                        pos_q <= pos_q - 1'b1;
                    end else begin
                        pos_q <= pos_q + 1'b1;
                    end
                end
                MODE_BLINK:  phase_q <= ~phase_q;
                default:     ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            led_n <= '1;
        end else begin
            case (mode)
                MODE_BINARY: led_n <= ~count_q;
                MODE_CHASE:  led_n <= ~(LED_ONE << pos_q);
                MODE_BLINK:  led_n <= phase_q ? '0 : '1;
                default:     led_n <= '1;
            endcase
        end
    end

endmodule

// File: tb/tb_blinky_sequencer.sv
// Self-checking bench for blinky_sequencer against a step-count based reference model.
module tb_blinky_sequencer;

    localparam int DIV = 10;
    localparam int DB  = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       btn_n = 1'b1;
    logic [5:0] led_n;
    logic [1:0] mode;

    int n_compared = 0;
    int n_mismatched = 0;

    blinky_sequencer #(
        .CLK_HZ          (100),
        .STEP_HZ         (10),
        .DEBOUNCE_CYCLES (DB)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .btn_n (btn_n),
        .led_n (led_n),
        .mode  (mode)
    );

    always #5 clk = ~clk;

    // Reference model: edges elapsed since the last reset/press, the selected
    // mode, and a run-length view of the sampled button level.
    int m_mode, m_edges, m_run, m_press_in;
    bit m_stable, m_fresh;
    int t_mode, t_edges, t_run, t_press_in;
    bit t_stable, t_fresh;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_mode <= 0; m_edges <= 0; m_run <= 0; m_press_in <= 0;
            m_stable <= 1'b1; m_fresh <= 1'b1;
        end else begin
            t_mode = m_mode; t_edges = m_edges; t_run = m_run;
            t_press_in = m_press_in; t_stable = m_stable; t_fresh = m_fresh;
            // An accepted press restarts the pattern three edges after the level is accepted.
            if (t_press_in == 1) begin
                t_mode = (t_mode + 1) % 3;
                t_edges = 0;
                t_fresh = 1'b0;
                t_press_in = 0;
            end else begin
                if (t_press_in > 1) t_press_in--;
                t_edges++;
            end
            if (btn_n != t_stable) begin
                t_run++;
                if (t_run == DB) begin
                    t_stable = btn_n;
                    t_run = 0;
                    if (!btn_n) t_press_in = 3;
                end
            end else begin
                t_run = 0;
            end
            m_mode <= t_mode; m_edges <= t_edges; m_run <= t_run;
            m_press_in <= t_press_in; m_stable <= t_stable; m_fresh <= t_fresh;
        end
    end

    function automatic logic [5:0] model_led(input int md, input int n);
        logic [5:0] v;
        int p;
        case (md)
            0: begin v = 6'(n % 64); return ~v; end
            1: begin
                p = n % 10;
                if (p > 5) p = 10 - p;
                v = 6'(1 << p);
                return ~v;
            end
            2: return (n % 2 == 1) ? 6'b000000 : 6'b111111;
            default: return 6'b111111;
        endcase
    endfunction

    function automatic bit exp_valid();
        return (m_edges != 0) || m_fresh;
    endfunction

    function automatic logic [5:0] exp_led();
        if (m_edges == 0) return 6'b111111;
        return model_led(m_mode, (m_edges - 1) / DIV);
    endfunction

    // Stimulus only: hold the button low long enough to be accepted, then release.
    task automatic drive_press();
        btn_n = 1'b0;
        repeat (DB + 2) @(negedge clk);
        btn_n = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        n_compared++;
        if (led_n !== 6'b111111) begin
            n_mismatched++;
            $display("FAIL reset_led: led_n=%b, want 111111", led_n);
        end
        n_compared++;
        if (mode !== 2'd0) begin
            n_mismatched++;
            $display("FAIL reset_mode: mode=%0d, want 0", mode);
        end
        reset = 1'b0;
    endtask

    task automatic test_idle();
        repeat (700) begin
            @(negedge clk);
            n_compared++;
            if (mode !== 2'(m_mode) || (exp_valid() && led_n !== exp_led())) begin
                n_mismatched++;
                $display("FAIL idle: mode=%0d led_n=%b, want mode=%0d led_n=%b", mode, led_n, m_mode, exp_led());
            end
            if (m_edges == 631 || m_edges == 641) begin
                n_compared++;
                if (led_n !== ((m_edges == 631) ? 6'b000000 : 6'b111111)) begin
                    n_mismatched++;
                    $display("FAIL idle_wrap: edges=%0d led_n=%b", m_edges, led_n);
                end
            end
        end
    endtask

    task automatic test_debounce_glitch();
        btn_n = 1'b0;
        repeat (DB - 1) @(negedge clk);
        btn_n = 1'b1;
        repeat (20) begin
            @(negedge clk);
            n_compared++;
            if (mode !== 2'd0 || led_n !== exp_led()) begin
                n_mismatched++;
                $display("FAIL glitch: mode=%0d led_n=%b, want mode=0 led_n=%b", mode, led_n, exp_led());
            end
        end
    endtask

    task automatic test_press_chase();
        int changes = 0;
        int budget = 40;
        logic [1:0] prev = mode;
        btn_n = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (mode !== prev) changes++;
            prev = mode;
        end
        btn_n = 1'b1;
        while (!(m_mode == 1 && m_edges >= 1) && budget > 0) begin
            @(negedge clk);
            if (mode !== prev) changes++;
            prev = mode;
            budget--;
        end
        n_compared++;
        if (budget == 0 || changes != 1 || mode !== 2'd1) begin
            n_mismatched++;
            $display("FAIL press_chase: mode=%0d changes=%0d budget=%0d, want mode=1 changes=1", mode, changes, budget);
        end
        n_compared++;
        if (led_n !== 6'b111110) begin
            n_mismatched++;
            $display("FAIL press_chase_led: led_n=%b, want 111110", led_n);
        end
    endtask

    task automatic test_chase_bounce();
        int seq [13] = '{0, 1, 2, 3, 4, 5, 4, 3, 2, 1, 0, 1, 2};
        int k;
        logic [5:0] one_cold;
        repeat (130) begin
            @(negedge clk);
            n_compared++;
            if (mode !== 2'(m_mode) || (exp_valid() && led_n !== exp_led())) begin
                n_mismatched++;
                $display("FAIL chase: mode=%0d led_n=%b, want mode=%0d led_n=%b", mode, led_n, m_mode, exp_led());
            end
            k = (m_edges - 1) / DIV;
            if (m_edges % DIV == 2 && k <= 12) begin
                one_cold = ~(6'b000001 << seq[k]);
                n_compared++;
                if (led_n !== one_cold) begin
                    n_mismatched++;
                    $display("FAIL chase_step%0d: led_n=%b, want %b", k, led_n, one_cold);
                end
            end
        end
    endtask

    task automatic test_blink();
        drive_press();
        repeat (60) begin
            @(negedge clk);
            n_compared++;
            if (mode !== 2'(m_mode) || (exp_valid() && led_n !== exp_led())) begin
                n_mismatched++;
                $display("FAIL blink: mode=%0d led_n=%b, want mode=%0d led_n=%b", mode, led_n, m_mode, exp_led());
            end
            if (m_edges % DIV == 2 && m_edges > 0) begin
                n_compared++;
                if (mode !== 2'd2 || led_n !== ((((m_edges - 1) / DIV) % 2 == 1) ? 6'b000000 : 6'b111111)) begin
                    n_mismatched++;
                    $display("FAIL blink_step: mode=%0d led_n=%b edges=%0d", mode, led_n, m_edges);
                end
            end
        end
    endtask

    task automatic test_wrap();
        int budget = 40;
        drive_press();
        while (!(m_mode == 0 && m_edges == 1) && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        n_compared++;
        if (budget == 0 || mode !== 2'd0 || led_n !== 6'b111111) begin
            n_mismatched++;
            $display("FAIL wrap: mode=%0d led_n=%b budget=%0d, want mode=0 led_n=111111", mode, led_n, budget);
        end
    endtask

    task automatic test_simultaneous();
        int budget = 60;
        while (!(m_edges % DIV == 3 && m_stable && m_run == 0 && m_press_in == 0) && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        // Press lands in the cycle where the prescaler sits at its last count.
        drive_press();
        budget = 40;
        while (!(m_mode == 1 && m_edges == DIV) && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        n_compared++;
        if (budget == 0 || mode !== 2'd1 || led_n !== 6'b111110) begin
            n_mismatched++;
            $display("FAIL simul_hold: mode=%0d led_n=%b budget=%0d, want mode=1 led_n=111110", mode, led_n, budget);
        end
        @(negedge clk);
        n_compared++;
        if (led_n !== 6'b111101) begin
            n_mismatched++;
            $display("FAIL simul_step: led_n=%b, want 111101", led_n);
        end
    endtask

    task automatic test_reset_mid();
        int budget = 150;
        while (!(m_mode == 1 && m_edges % DIV == 5 && ((m_edges - 1) / DIV) % 10 == 3) && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        n_compared++;
        if (budget == 0 || led_n !== 6'b110111) begin
            n_mismatched++;
            $display("FAIL reset_mid_pre: led_n=%b budget=%0d, want 110111", led_n, budget);
        end
        @(posedge clk);
        #3 reset = 1'b1;
        #1;
        n_compared++;
        if (led_n !== 6'b111111 || mode !== 2'd0) begin
            n_mismatched++;
            $display("FAIL reset_mid: mode=%0d led_n=%b, want mode=0 led_n=111111", mode, led_n);
        end
        @(negedge clk);
        reset = 1'b0;
        repeat (30) begin
            @(negedge clk);
            n_compared++;
            if (mode !== 2'(m_mode) || (exp_valid() && led_n !== exp_led())) begin
                n_mismatched++;
                $display("FAIL reset_restart: mode=%0d led_n=%b, want mode=%0d led_n=%b", mode, led_n, m_mode, exp_led());
            end
            if (m_edges == 12) begin
                n_compared++;
                if (led_n !== 6'b111110) begin
                    n_mismatched++;
                    $display("FAIL reset_count1: led_n=%b, want 111110", led_n);
                end
            end
        end
    endtask

    task automatic test_random_buttons();
        int low_len, high_len;
        for (int ep = 0; ep < 25; ep++) begin
            low_len = $urandom_range(9, 1);
            high_len = $urandom_range(25, 5);
            for (int c = 0; c < low_len + high_len; c++) begin
                btn_n = (c < low_len) ? 1'b0 : 1'b1;
                @(negedge clk);
                n_compared++;
                if (mode !== 2'(m_mode) || (exp_valid() && led_n !== exp_led())) begin
                    n_mismatched++;
                    $display("FAIL random ep%0d: mode=%0d led_n=%b, want mode=%0d led_n=%b", ep, mode, led_n, m_mode, exp_led());
                end
            end
        end
        btn_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_idle();
        test_debounce_glitch();
        test_press_chase();
        test_chase_bounce();
        test_blink();
        test_wrap();
        test_simultaneous();
        test_reset_mid();
        test_random_buttons();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
